uart_transmitter: RTL and testbench

Serialises bytes onto the UART TxD line as async frames (start, 8 data bits LSB-first, optional parity, 1 or 2 stop bits). It is the transmit-side counterpart of uart_receiver and shares the same clock and baud parameters. A one-entry holding register with a valid/ready handshake allows back-to-back frames with no idle gap.

---
 rtl/uart_transmitter.sv | 120 ++++++++++++
 tb/tb_uart_transmitter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// UART transmit side: start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
// A one-entry holding register behind a valid/ready handshake allows gap-free back-to-back frames.
module uart_transmitter #(
   parameter int clk_freq   = 100_000_000,
   parameter int baud_rate  = 9600,
   parameter bit parity_en  = 1'b0,
   parameter bit parity_odd = 1'b0,
   parameter int stop_bits  = 1
) (
   input  logic       clk_fpga,
   input  logic       reset,
   input  logic [7:0] TxData,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       TxD,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int div_counter = clk_freq / baud_rate;
   localparam int cnt_w       = (div_counter < 2) ? 1 : $clog2(div_counter);

   localparam logic [cnt_w-1:0] baud_last = cnt_w'(div_counter - 1);
   localparam logic [2:0]       stop_last = 3'(stop_bits - 1);

   if (div_counter < 2) begin : g_bad_div
      $error("uart_transmitter: clk_freq/baud_rate must be at least 2");
   end
   if (stop_bits != 1 && stop_bits != 2) begin : g_bad_stop
      $error("uart_transmitter: stop_bits must be 1 or 2");
   end

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t           state, state_next;
   logic [cnt_w-1:0] baud_cnt;
   logic [2:0]       bit_cnt;
   logic [7:0]       hold_data;
   logic             hold_full;
   logic [7:0]       shift, shift_next;
   logic             par_bit;
   logic             txd_next;

   logic bit_end, last_stop, load, accept;

   assign bit_end   = (state != IDLE) && (baud_cnt == baud_last);
   assign last_stop = (state == STOP) && bit_end && (bit_cnt == stop_last);
   // Loading frees the holding register, so a load can never coincide with an accept.
   assign load      = hold_full && ((state == IDLE) || last_stop);
   assign accept    = tx_valid && !hold_full;

   assign shift_next = load                          ? hold_data :
                       ((state == DATA) && bit_end)  ? {1'b0, shift[7:1]} :
                                                       shift;

   always_ff @(posedge clk_fpga or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (load) state_next = START;
         START:   if (bit_end) state_next = DATA;
         DATA:    if (bit_end && (bit_cnt == 3'd7)) state_next = parity_en ? PARITY : STOP;
         PARITY:  if (bit_end) state_next = STOP;
         STOP:    if (last_stop) state_next = load ? START : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // TxD is registered, so it is decoded from the state being entered.
   always_comb begin
      txd_next = 1'b1;
      case (state_next)
         START:   txd_next = 1'b0;
         DATA:    txd_next = shift_next[0];
         PARITY:  txd_next = par_bit;
         default: txd_next = 1'b1;
      endcase
      tx_ready = !hold_full;
      tx_busy  = (state != IDLE);
      tx_done  = last_stop;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_fpga or negedge reset) begin
      if (!reset) begin
         hold_full <= 1'b0;
         hold_data <= '0;
         shift     <= '0;
         par_bit   <= 1'b0;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         TxD       <= 1'b1;
      end else begin
         if (accept) begin
            hold_full <= 1'b1;
            hold_data <= TxData;
         end else if (load) begin
            hold_full <= 1'b0;
         end

         shift <= shift_next;
         if (load) par_bit <= ^hold_data ^ parity_odd;

         if (load || (state == IDLE) || bit_end) baud_cnt <= '0;
         else                                    baud_cnt <= baud_cnt + 1'b1;

         // Bit counter restarts on every state change; it serves both DATA and STOP.
         if (state_next != state) bit_cnt <= '0;
         else if (bit_end)        bit_cnt <= bit_cnt + 3'd1;

         TxD <= txd_next;
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at 16 clocks per bit, covering four
// frame formats: 8N1, even parity, odd parity and two stop bits.
module tb_uart_transmitter;

   logic       clk_fpga = 1'b0;
   logic       reset    = 1'b0;
   logic [7:0] tx_data  [4];
   logic       tx_valid [4];
   logic       tx_ready [4];
   logic       txd      [4];
   logic       busy     [4];
   logic       done     [4];

   int total = 0;
   int bad   = 0;

   always #5 clk_fpga = ~clk_fpga;

   uart_transmitter #(.clk_freq(16), .baud_rate(1), .parity_en(1'b0), .parity_odd(1'b0), .stop_bits(1)) u_8n1 (
      .clk_fpga(clk_fpga), .reset(reset), .TxData(tx_data[0]), .tx_valid(tx_valid[0]),
      .tx_ready(tx_ready[0]), .TxD(txd[0]), .tx_busy(busy[0]), .tx_done(done[0]));
   uart_transmitter #(.clk_freq(16), .baud_rate(1), .parity_en(1'b1), .parity_odd(1'b0), .stop_bits(1)) u_even (
      .clk_fpga(clk_fpga), .reset(reset), .TxData(tx_data[1]), .tx_valid(tx_valid[1]),
      .tx_ready(tx_ready[1]), .TxD(txd[1]), .tx_busy(busy[1]), .tx_done(done[1]));
   uart_transmitter #(.clk_freq(16), .baud_rate(1), .parity_en(1'b1), .parity_odd(1'b1), .stop_bits(1)) u_odd (
      .clk_fpga(clk_fpga), .reset(reset), .TxData(tx_data[2]), .tx_valid(tx_valid[2]),
      .tx_ready(tx_ready[2]), .TxD(txd[2]), .tx_busy(busy[2]), .tx_done(done[2]));
   uart_transmitter #(.clk_freq(16), .baud_rate(1), .parity_en(1'b0), .parity_odd(1'b0), .stop_bits(2)) u_2stop (
      .clk_fpga(clk_fpga), .reset(reset), .TxData(tx_data[3]), .tx_valid(tx_valid[3]),
      .tx_ready(tx_ready[3]), .TxD(txd[3]), .tx_busy(busy[3]), .tx_done(done[3]));

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk_fpga);
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({txd[i], tx_ready[i], busy[i], done[i]} !== 4'b1100) begin
            bad++;
            $display("FAIL reset_values dut%0d: {txd,ready,busy,done} got %b want 1100", i,
                     {txd[i], tx_ready[i], busy[i], done[i]});
         end
      end
      reset = 1'b1;
      repeat (2) @(negedge clk_fpga);
   endtask

   // 0xA5 as 8N1: start, 1,0,1,0,0,1,0,1, stop.
   task automatic test_single_frame();
      logic [0:9] seq;
      logic [2:0] exp;
      seq = 10'b0101001011;
      tx_data[0] = 8'hA5; tx_valid[0] = 1'b1;
      @(negedge clk_fpga);
      tx_valid[0] = 1'b0;
      total++;
      if ({txd[0], tx_ready[0]} !== 2'b10) begin
         bad++;
         $display("FAIL single_accept {txd,ready} got %b want 10", {txd[0], tx_ready[0]});
      end
      for (int k = 1; k <= 161; k++) begin
         @(negedge clk_fpga);
         exp = (k <= 160) ? {seq[(k-1)/16], 1'b1, (k == 160)} : 3'b100;
         total++;
         if ({txd[0], busy[0], done[0]} !== exp) begin
            bad++;
            $display("FAIL single_line clk %0d {txd,busy,done} got %b want %b", k,
                     {txd[0], busy[0], done[0]}, exp);
         end
         if (k == 1) begin
            total++;
            if (tx_ready[0] !== 1'b1) begin
               bad++;
               $display("FAIL single_ready_after_load got %b want 1", tx_ready[0]);
            end
         end
      end
   endtask

   // 0x00 then 0xFF queued mid-frame; second start bit must follow the first stop with no gap.
   task automatic test_back_to_back();
      logic [0:19] seq;
      logic [2:0]  exp;
      logic        exp_ready;
      seq = 20'b0000000001_0111111111;
      @(negedge clk_fpga);
      tx_data[0] = 8'h00; tx_valid[0] = 1'b1;
      @(negedge clk_fpga);
      tx_valid[0] = 1'b0;
      for (int k = 1; k <= 321; k++) begin
         @(negedge clk_fpga);
         exp = (k <= 320) ? {seq[(k-1)/16], 1'b1, (k == 160 || k == 320)} : 3'b100;
         exp_ready = !(k >= 41 && k <= 160);
         total++;
         if ({txd[0], busy[0], done[0]} !== exp) begin
            bad++;
            $display("FAIL b2b_line clk %0d {txd,busy,done} got %b want %b", k,
                     {txd[0], busy[0], done[0]}, exp);
         end
         total++;
         if (tx_ready[0] !== exp_ready) begin
            bad++;
            $display("FAIL b2b_ready clk %0d got %b want %b", k, tx_ready[0], exp_ready);
         end
         if (k == 40) begin tx_data[0] = 8'hFF; tx_valid[0] = 1'b1; end
         if (k == 41) tx_valid[0] = 1'b0;
      end
   endtask

   // 0x07 has three ones: even parity bit 1, odd parity bit 0; 11-bit frames.
   task automatic test_parity();
      logic [0:10] seq [1:2];
      logic [2:0]  exp;
      seq[1] = 11'b01110000011;
      seq[2] = 11'b01110000001;
      @(negedge clk_fpga);
      tx_data[1] = 8'h07; tx_valid[1] = 1'b1;
      tx_data[2] = 8'h07; tx_valid[2] = 1'b1;
      @(negedge clk_fpga);
      tx_valid[1] = 1'b0; tx_valid[2] = 1'b0;
      for (int k = 1; k <= 177; k++) begin
         @(negedge clk_fpga);
         for (int i = 1; i <= 2; i++) begin
            exp = (k <= 176) ? {seq[i][(k-1)/16], 1'b1, (k == 176)} : 3'b100;
            total++;
            if ({txd[i], busy[i], done[i]} !== exp) begin
               bad++;
               $display("FAIL parity dut%0d clk %0d {txd,busy,done} got %b want %b", i, k,
                        {txd[i], busy[i], done[i]}, exp);
            end
         end
      end
   endtask

   // 0x81 with two stop bits: line high for clocks 145..176, tx_done on 176.
   task automatic test_two_stop();
      logic [0:10] seq;
      logic [2:0]  exp;
      seq = 11'b01000000111;
      @(negedge clk_fpga);
      tx_data[3] = 8'h81; tx_valid[3] = 1'b1;
      @(negedge clk_fpga);
      tx_valid[3] = 1'b0;
      for (int k = 1; k <= 177; k++) begin
         @(negedge clk_fpga);
         exp = (k <= 176) ? {seq[(k-1)/16], 1'b1, (k == 176)} : 3'b100;
         total++;
         if ({txd[3], busy[3], done[3]} !== exp) begin
            bad++;
            $display("FAIL two_stop clk %0d {txd,busy,done} got %b want %b", k,
                     {txd[3], busy[3], done[3]}, exp);
         end
      end
   endtask

   // tx_valid held high across four bytes; a bench-side receiver decodes the line.
   task automatic test_handshake();
      logic [7:0] q  [4];
      logic [7:0] rx [4];
      logic [7:0] shreg;
      int sent, nrx, ndone, nbusy, pos;
      logic in_frame, pend;
      q[0] = 8'h3C; q[1] = 8'hC3; q[2] = 8'h5A; q[3] = 8'h96;
      sent = 0; nrx = 0; ndone = 0; nbusy = 0; pos = 0; in_frame = 1'b0; shreg = '0;
      for (int i = 0; i < 4; i++) rx[i] = '0;
      @(negedge clk_fpga);
      tx_data[0] = q[0]; tx_valid[0] = 1'b1;
      for (int c = 0; c < 700; c++) begin
         pend = tx_valid[0] && tx_ready[0];
         @(negedge clk_fpga);
         if (pend) begin
            sent++;
            if (sent < 4) tx_data[0] = q[sent];
            else          tx_valid[0] = 1'b0;
         end
         if (done[0]) ndone++;
         if (busy[0]) nbusy++;
         if (in_frame) begin
            pos++;
            if (pos >= 24 && pos <= 136 && (pos % 16) == 8) shreg = {txd[0], shreg[7:1]};
            if (pos == 160) begin
               if (nrx < 4) rx[nrx] = shreg;
               nrx++;
               in_frame = 1'b0;
            end
         end else if (txd[0] == 1'b0) begin
            in_frame = 1'b1;
            pos = 1;
         end
      end
      total++;
      if (sent != 4) begin bad++; $display("FAIL hs_accepts got %0d want 4", sent); end
      total++;
      if (nrx != 4) begin bad++; $display("FAIL hs_frames got %0d want 4", nrx); end
      total++;
      if (ndone != 4) begin bad++; $display("FAIL hs_done_pulses got %0d want 4", ndone); end
      total++;
      if (nbusy != 640) begin bad++; $display("FAIL hs_busy_clocks got %0d want 640", nbusy); end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (rx[i] !== q[i]) begin
            bad++;
            $display("FAIL hs_byte%0d got %h want %h", i, rx[i], q[i]);
         end
      end
   endtask

   // Reset during DATA with a byte held: line high at once, nothing sent afterwards.
   task automatic test_reset_mid_frame();
      int ndone, nlow;
      ndone = 0; nlow = 0;
      @(negedge clk_fpga);
      tx_data[0] = 8'h00; tx_valid[0] = 1'b1;
      @(negedge clk_fpga);
      tx_valid[0] = 1'b0;
      for (int k = 1; k <= 50; k++) begin
         @(negedge clk_fpga);
         if (k == 45) begin tx_data[0] = 8'h55; tx_valid[0] = 1'b1; end
         if (k == 46) tx_valid[0] = 1'b0;
      end
      total++;
      if ({txd[0], tx_ready[0]} !== 2'b00) begin
         bad++;
         $display("FAIL mid_pre_reset {txd,ready} got %b want 00", {txd[0], tx_ready[0]});
      end
      #2 reset = 1'b0;
      #1;
      total++;
      if ({txd[0], tx_ready[0], busy[0], done[0]} !== 4'b1100) begin
         bad++;
         $display("FAIL mid_reset_immediate {txd,ready,busy,done} got %b want 1100",
                  {txd[0], tx_ready[0], busy[0], done[0]});
      end
      repeat (2) @(negedge clk_fpga);
      reset = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk_fpga);
         if (done[0]) ndone++;
         if (!txd[0]) nlow++;
      end
      total++;
      if (ndone != 0) begin bad++; $display("FAIL mid_no_done got %0d pulses want 0", ndone); end
      total++;
      if (nlow != 0) begin bad++; $display("FAIL mid_line_idle got %0d low clocks want 0", nlow); end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         tx_data[i]  = '0;
         tx_valid[i] = 1'b0;
      end
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_parity();
      test_two_stop();
      test_handshake();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
